// File: rtl/rom_addr_sequencer_if.sv
// Control/status bundle between the board wrapper and the ROM address sequencer.
// The wrapper drives the controls; the sequencer returns the address and pulses.
interface rom_addr_sequencer_if #(
  parameter int ENDERECO = 2
);
  logic                modo;
  logic                passo;
  logic                direcao;
  logic                carga;
  logic [ENDERECO-1:0] endereco_carga;
  logic [ENDERECO-1:0] endereco;
  logic                atualizado;
  logic                volta;

  modport master (
    output modo,
    output passo,
    output direcao,
    output carga,
    output endereco_carga,
    input  endereco,
    input  atualizado,
    input  volta
  );

  modport slave (
    input  modo,
    input  passo,
    input  direcao,
    input  carga,
    input  endereco_carga,
    output endereco,
    output atualizado,
    output volta
  );
endinterface

// File: rtl/rom_addr_sequencer.sv
// Sequenced address for the 4-entry pattern ROM: manual step from a switch
// or automatic step every TICKS cycles, with up/down, load and wrap flag.
module rom_addr_sequencer #(
  parameter int ENDERECO = 2,
  parameter int TICKS    = 4
) (
  input  logic clk_2,
  input  logic reset,
  rom_addr_sequencer_if.slave bus
);
  localparam int PW = $clog2(TICKS);

  logic                s1;
  logic                s2;
  logic                h;
  logic                modo_q;
  logic [PW-1:0]       presc;
  logic [ENDERECO-1:0] end_q;
  logic                atual_q;
  logic                volta_q;

  logic                step_edge;
  logic                modo_chg;
  logic                adv;
  logic                wrap;
  logic [ENDERECO-1:0] next_end;

  assign bus.endereco   = end_q;
  assign bus.atualizado = atual_q;
  assign bus.volta      = volta_q;

  // Advance request and next address with its wrap flag.
  always_comb begin
    step_edge = s2 & ~h;
    modo_chg  = bus.modo != modo_q;
    adv       = bus.modo ? (presc == PW'(TICKS - 1)) : step_edge;
    if (bus.direcao) begin
      next_end = end_q - 1'b1;
      wrap     = end_q == '0;
    end else begin
      next_end = end_q + 1'b1;
      wrap     = end_q == '1;
    end
  end

  // Synchronize passo, then apply load > mode change > advance > hold.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      h       <= 1'b0;
      modo_q  <= 1'b0;
      presc   <= '0;
      end_q   <= '0;
      atual_q <= 1'b0;
      volta_q <= 1'b0;
    end else begin
      s1     <= bus.passo;
      s2     <= s1;
      h      <= s2;
      modo_q <= bus.modo;
      if (bus.carga) begin
        end_q   <= bus.endereco_carga;
        presc   <= '0;
        atual_q <= 1'b1;
        volta_q <= 1'b0;
      end else if (modo_chg) begin
        presc   <= '0;
        atual_q <= 1'b0;
        volta_q <= 1'b0;
      end else if (adv) begin
        end_q   <= next_end;
        presc   <= '0;
        atual_q <= 1'b1;
        volta_q <= wrap;
      end else begin
        presc   <= bus.modo ? presc + PW'(1) : '0;
        atual_q <= 1'b0;
        volta_q <= 1'b0;
      end
    end
  end
endmodule
